// File: rtl/fourier_top.sv
// 8-point DFT engine over a fixed sample ROM, one shared multiply-accumulate datapath.
// Optional macro FOURIER_ROUND_EN: round-half-up before the >>>14 store scaling (default truncates).
module fourier_top (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] regAddr,
    output logic [31:0] regData,
    output logic        done
);

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int AW = 40;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_STORE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           k_q, k_d;
    logic [2:0]           n_q, n_d;
    logic signed [AW-1:0] acc_re_q, acc_re_d;
    logic signed [AW-1:0] acc_im_q, acc_im_d;
    logic                 done_q, done_d;
    logic [31:0]          result_q [N];

    logic                 wr_en;
    logic [31:0]          wr_data;
    logic [2:0]           m_idx;
    logic signed [DW-1:0] x_n;
    logic signed [DW-1:0] c_m;
    logic signed [DW-1:0] s_m;
    logic signed [31:0]   prod_re;
    logic signed [31:0]   prod_im;
    logic signed [AW-1:0] prod_re_ext;
    logic signed [AW-1:0] prod_im_ext;

    function automatic logic signed [DW-1:0] sample_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'sd4096;
            3'd1:    return 16'sd2896;
            3'd2:    return 16'sd0;
            3'd3:    return -16'sd2896;
            3'd4:    return -16'sd4096;
            3'd5:    return -16'sd2896;
            3'd6:    return 16'sd0;
            default: return 16'sd2896;
        endcase
    endfunction

    function automatic logic signed [DW-1:0] cos_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'sd16384;
            3'd1:    return 16'sd11585;
            3'd2:    return 16'sd0;
            3'd3:    return -16'sd11585;
            3'd4:    return -16'sd16384;
            3'd5:    return -16'sd11585;
            3'd6:    return 16'sd0;
            default: return 16'sd11585;
        endcase
    endfunction

    function automatic logic signed [DW-1:0] sin_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'sd0;
            3'd1:    return 16'sd11585;
            3'd2:    return 16'sd16384;
            3'd3:    return 16'sd11585;
            3'd4:    return 16'sd0;
            3'd5:    return -16'sd11585;
            3'd6:    return -16'sd16384;
            default: return -16'sd11585;
        endcase
    endfunction

    // Q14 accumulator back to a saturated 16-bit component.
    function automatic logic [DW-1:0] scale_sat(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] biased;
        logic signed [AW-1:0] shifted;
`ifdef FOURIER_ROUND_EN
        biased = acc + 40'sd8192;
`else
        biased = acc;
`endif
        shifted = biased >>> 14;
        if (shifted > 40'sd32767) begin
            return 16'h7FFF;
        end else if (shifted < -40'sd32768) begin
            return 16'h8000;
        end else begin
            return shifted[DW-1:0];
        end
    endfunction

    // A 3-bit product wraps naturally, which is exactly (k*n) mod 8.
    assign m_idx       = k_q * n_q;
    assign x_n         = sample_rom(n_q);
    assign c_m         = cos_rom(m_idx);
    assign s_m         = sin_rom(m_idx);
    assign prod_re     = x_n * c_m;
    assign prod_im     = x_n * s_m;
    assign prod_re_ext = {{(AW-32){prod_re[31]}}, prod_re};
    assign prod_im_ext = {{(AW-32){prod_im[31]}}, prod_im};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            k_q      <= 3'd0;
            n_q      <= 3'd0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            n_q      <= n_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        n_d      = n_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        done_d   = done_q;
        wr_en    = 1'b0;
        wr_data  = {scale_sat(acc_re_q), scale_sat(acc_im_q)};
        case (state_q)
            S_IDLE: begin
                state_d  = S_MAC;
                k_d      = 3'd0;
                n_d      = 3'd0;
                acc_re_d = '0;
                acc_im_d = '0;
            end
            S_MAC: begin
                acc_re_d = acc_re_q + prod_re_ext;
                acc_im_d = acc_im_q - prod_im_ext;
                if (n_q == 3'd7) begin
                    state_d = S_STORE;
                end else begin
                    n_d = n_q + 3'd1;
                end
            end
            S_STORE: begin
                wr_en    = 1'b1;
                acc_re_d = '0;
                acc_im_d = '0;
                if (k_q != 3'd7) begin
                    k_d     = k_q + 3'd1;
                    n_d     = 3'd0;
                    state_d = S_MAC;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Result bins are plain registers so reset can clear them.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_result
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    result_q[gi] <= 32'd0;
                end else if (wr_en && (k_q == 3'(gi))) begin
                    result_q[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign regData = (regAddr < 32'd8) ? result_q[regAddr[2:0]] : 32'd0;
    assign done    = done_q;

endmodule

// File: tb/tb_fourier_top.sv
// Directed bench for fourier_top: done timing, bin values, read-port decode and mid-run reset.
module tb_fourier_top;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] regAddr;
    logic [31:0] regData;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

`ifdef FOURIER_ROUND_EN
    localparam logic [31:0] BIN_PEAK = 32'h3FFF0000;
`else
    localparam logic [31:0] BIN_PEAK = 32'h3FFE0000;
`endif

    // Hand-computed: bins 3 and 5 real = floor(17088/16384) = 1 (also 1 when rounded).
    logic [31:0] exp_bins [8];

    fourier_top dut (
        .clk     (clk),
        .reset   (reset),
        .regAddr (regAddr),
        .regData (regData),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Edges counted from reset release; regAddr parked on bin 1.
    task automatic run_edges(input string phase, input int first_edge, input int last_edge);
        for (int e = first_edge; e <= last_edge; e++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("%s done e%0d", phase, e), {31'd0, done}, {31'd0, (e >= 73)});
            if (e <= 18) begin
                check_eq($sformatf("%s bin1 pending e%0d", phase, e), regData, 32'd0);
            end else if (e == 19) begin
                check_eq($sformatf("%s bin1 stored e%0d", phase, e), regData, exp_bins[1]);
            end
        end
    endtask

    task automatic sweep_bins(input string phase);
        for (int a = 0; a < 8; a++) begin
            regAddr = 32'(a);
            #1;
            check_eq($sformatf("%s bin%0d", phase, a), regData, exp_bins[a]);
            check_eq($sformatf("%s done at bin%0d", phase, a), {31'd0, done}, 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #3000;
        $display("FAIL watchdog: simulation exceeded 300 cycles, done=%0b", done);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_bins = '{32'h0, BIN_PEAK, 32'h0, 32'h00010000, 32'h0, 32'h00010000, 32'h0, BIN_PEAK};
        reset   = 1'b1;
        regAddr = 32'd0;
        #12;
        check_eq("reset done", {31'd0, done}, 32'd0);
        check_eq("reset bin0", regData, 32'd0);
        regAddr = 32'd1;
        #1;
        check_eq("reset bin1", regData, 32'd0);
        #9;
        reset = 1'b0;

        run_edges("run1", 1, 80);
        sweep_bins("run1");

        regAddr = 32'd8;
        #1;
        check_eq("addr 0x8", regData, 32'd0);
        regAddr = 32'd9;
        #1;
        check_eq("addr 0x9 no alias", regData, 32'd0);
        regAddr = 32'hFFFFFFFF;
        #1;
        check_eq("addr 0xFFFFFFFF", regData, 32'd0);
        regAddr = 32'h00000101;
        #1;
        check_eq("addr 0x101 no alias", regData, 32'd0);
        regAddr = 32'd7;
        #1;
        check_eq("addr back to 7", regData, exp_bins[7]);

        // Fresh run, then interrupt it during bin 4.
        @(posedge clk);
        #1;
        reset   = 1'b1;
        regAddr = 32'd1;
        #20;
        reset = 1'b0;
        run_edges("run2", 1, 40);
        #1;
        reset = 1'b1;
        #1;
        check_eq("midreset done", {31'd0, done}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            regAddr = 32'(a);
            #1;
            check_eq($sformatf("midreset bin%0d", a), regData, 32'd0);
        end
        regAddr = 32'd1;
        #2;
        reset = 1'b0;
        run_edges("run3", 1, 75);
        sweep_bins("run3");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fourier_top.md
# fourier_top

8-point discrete Fourier transform engine over a fixed internal sample set. After reset release it sequentially computes all 8 complex bins with a single multiply-accumulate datapath, then raises `done`. Results are read back through a combinational register-read port (`regAddr`/`regData`). It is the top of the Fourier simulation subsystem.

## Interface
- `N`, 8: transform length; fixed, not a general parameter.
- `DW`, 16: sample, twiddle and result-component width (signed).
- `AW`, 40: accumulator width (signed).
- `clk` input 1: single clock; rising edge active.
- `reset` input 1: asynchronous, active-high reset.
- `regAddr` input 32: result bin select.
- `regData` output 32: `{Re[15:0], Im[15:0]}` of the selected bin, two's complement.
- `done` output 1: level; high when all bins are valid.

## Operation
- Sample ROM `x[0..7]`, signed 16-bit: {4096, 2896, 0, -2896, -4096, -2896, 0, 2896}.
- Twiddle ROMs are indexed by `m = (k*n) mod 8`:
  - `C[m] = round(16384*cos(2πm/8))`, giving {16384, 11585, 0, -11585, -16384, -11585, 0, 11585}.
  - `S[m] = round(16384*sin(2πm/8))`, giving {0, 11585, 16384, 11585, 0, -11585, -16384, -11585}.
- `X[k] = Σ x[n]·(C − jS)`:
  - `accRe += x·C`
  - `accIm −= x·S`
  - Products are signed 32-bit, sign-extended into 40-bit accumulators. No overflow is possible.
- Store scaling: `acc >>> 14` (arithmetic shift), then saturate to [-32768, 32767]. Rounding is controlled by the Configuration section.
- Result RAM holds 8 × 32-bit entries and resets to 0.
- Read-out:
  - `regData` = `result[regAddr[2:0]]` when `regAddr < 8`; otherwise 0.
  - The read path is purely combinational and is readable at any time. Before completion, bins not yet stored read 0.
- FSM states:
  - IDLE → MAC: on the first clock after reset release; clears k, n and the accumulators.
  - MAC: one product per clock, `n` = 0..7. After `n` = 7 is accumulated → STORE.
  - STORE: writes bin `k` and clears the accumulators.
    - If `k` < 7: `k++`, `n` = 0, → MAC.
    - Else → DONE.
  - DONE: terminal; `done` = 1. Stays there until reset.
- Reset, including mid-computation: asynchronously returns to IDLE, clears the accumulators, k, n, the result RAM and `done`. Computation restarts from bin 0 after release.

## Timing
- Reset values: `done` = 0, `regData` = 0 (all bins 0), state IDLE.
- Rising edge 1 after reset release: IDLE → MAC.
- Each bin takes 9 edges (8 MAC + 1 STORE). Bin `k` is written on edge `1 + 9(k+1)`.
- `done` rises registered on edge 73, the same edge that stores bin 7. It then stays high.
- `regData` follows a `regAddr` change combinationally, with zero cycles of latency. This holds whether the address changes every cycle or after `done`.
- `regAddr` has no effect on the computation.

## Configuration
- `FOURIER_ROUND_EN`
  - Defined: round-half-up before the shift, i.e. `(acc + 8192) >>> 14`, then saturate.
  - Undefined (default): truncate, i.e. `acc >>> 14` (floor toward −∞).
- Expected bin 1 real part for the default ROM:
  - With the macro: 16383.
  - Without the macro: 16382.

## Test plan
- Reset held for 22 ns, released, `regAddr` = 0:
  - `done` = 0 through edge 72.
  - `done` = 1 from edge 73 onward.
  - `regData` = 0 before edge 10.
- After `done`, step `regAddr` = 0..7 once per clock while `done` is high (truncation build):
  - Bin 1 = `0x3FFE0000`, bin 7 = `0x3FFE0000`.
  - Bins 0, 2–6 have real and imaginary parts within ±1 of 0 (exact values per the formula).
- Same sweep with `FOURIER_ROUND_EN`: bin 1 and bin 7 = `0x3FFF0000`.
- After `done`, `regAddr` = 8, 9, 0xFFFFFFFF → `regData` = 0. `regAddr` = 0x00000009 must not alias to bin 1.
- Reset pulsed at edge 40 (mid-bin 4):
  - `done` = 0 and all bins read 0 immediately.
  - After release, `done` rises again exactly 73 edges later, with identical results.
- Simulation run of 300 cycles completes with `done` = 1 well before the timeout.
